// File: rtl/fetch_unit_pkg.sv
// Shared definitions for the IF stage: data width, the NOP word, fetch FSM
// state encodings and the PC increment helper.
package fetch_unit_pkg;

  localparam int XLEN = 32;

  localparam logic [XLEN-1:0] NOP_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WAIT  = 2'd1,
    ST_FULL  = 2'd2,
    ST_DRAIN = 2'd3
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pc_plus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_unit_sat_counter.sv
// Saturating up-counter used for the fetch stage's performance counters;
// holds at all-ones instead of wrapping.
module fetch_unit_sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [CNT_W-1:0] count
);

  logic [CNT_W-1:0] count_q;
  logic [CNT_W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (inc && (count_q != {CNT_W{1'b1}})) begin
      count_d = count_q + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/fetch_unit.sv
// IF stage plus IF/ID register: owns the PC, runs the req/ack instruction
// fetch, parks one word while the pipe is stalled and applies redirects.
module fetch_unit
  import fetch_unit_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             PC_Wr_en,
  input  logic             IF_ID_Wr_en,
  input  logic             IF_ID_flush,
  input  logic             Branch_taken,
  input  logic [31:0]      Branch_target,
  input  logic             Jump_en,
  input  logic [31:0]      Jump_target,
  input  logic             imem_ack,
  input  logic [31:0]      imem_rdata,
  output logic             imem_req,
  output logic [31:0]      imem_addr,
  output logic [31:0]      IF_ID_Instruction,
  output logic [31:0]      IF_ID_PC_plus4,
  output logic             IF_ID_valid,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count,
  output logic [1:0]       dbg_state
);

  // Handshake: imem_req is held high with imem_addr stable until imem_ack is
  // seen; one word transfers on each cycle where imem_req && imem_ack.

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  drain_addr_q, drain_addr_d;
  logic [31:0]  buf_q, buf_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc4_q, pc4_d;
  logic         valid_q, valid_d;

  logic         redirect;
  logic [31:0]  target;
  logic         advance;
  logic         word_avail;
  logic [31:0]  word;
  logic         stall_inc;
  logic         flush_inc;

  assign redirect = Branch_taken | Jump_en;
  assign target   = Branch_taken ? Branch_target : Jump_target;
  // A word is consumed only when PC and IF/ID both move, so it is never
  // duplicated by a refetch nor lost to a held IF/ID.
  assign advance  = PC_Wr_en & IF_ID_Wr_en;

  always_comb begin
    state_d      = state_q;
    pc_d         = pc_q;
    drain_addr_d = drain_addr_q;
    buf_d        = buf_q;
    word_avail   = 1'b0;
    word         = imem_rdata;
    case (state_q)
      ST_IDLE: begin
        state_d = ST_WAIT;
        if (redirect) begin
          pc_d = target;
        end
      end
      ST_WAIT: begin
        if (redirect) begin
          pc_d = target;
          if (!imem_ack) begin
            state_d      = ST_DRAIN;
            drain_addr_d = pc_q;
          end
        end else if (imem_ack) begin
          if (advance) begin
            word_avail = 1'b1;
            pc_d       = pc_plus4(pc_q);
          end else begin
            state_d = ST_FULL;
            buf_d   = imem_rdata;
          end
        end
      end
      ST_FULL: begin
        if (redirect) begin
          pc_d    = target;
          state_d = ST_WAIT;
        end else if (advance) begin
          word_avail = 1'b1;
          word       = buf_q;
          pc_d       = pc_plus4(pc_q);
          state_d    = ST_WAIT;
        end
      end
      ST_DRAIN: begin
        // The outstanding request must complete; its data belongs to the
        // abandoned path and is dropped.
        if (redirect) begin
          pc_d = target;
        end
        if (imem_ack) begin
          state_d = ST_WAIT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_comb begin
    instr_d = instr_q;
    pc4_d   = pc4_q;
    valid_d = valid_q;
    if (IF_ID_flush) begin
      instr_d = NOP_WORD;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end else if (!IF_ID_Wr_en) begin
      instr_d = instr_q;
    end else if (word_avail) begin
      instr_d = word;
      pc4_d   = pc_plus4(pc_q);
      valid_d = 1'b1;
    end else begin
      instr_d = NOP_WORD;
      pc4_d   = 32'h0;
      valid_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      pc_q         <= RESET_PC;
      drain_addr_q <= RESET_PC;
      buf_q        <= NOP_WORD;
      instr_q      <= NOP_WORD;
      pc4_q        <= 32'h0;
      valid_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      pc_q         <= pc_d;
      drain_addr_q <= drain_addr_d;
      buf_q        <= buf_d;
      instr_q      <= instr_d;
      pc4_q        <= pc4_d;
      valid_q      <= valid_d;
    end
  end

  assign imem_req  = (state_q == ST_WAIT) || (state_q == ST_DRAIN);
  assign imem_addr = (state_q == ST_DRAIN) ? drain_addr_q : pc_q;

  assign IF_ID_Instruction = instr_q;
  assign IF_ID_PC_plus4    = pc4_q;
  assign IF_ID_valid       = valid_q;
  assign dbg_state         = state_q;

  assign stall_inc = ~IF_ID_Wr_en & ~IF_ID_flush;
  assign flush_inc = IF_ID_flush;

  fetch_unit_sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (stall_inc),
    .count (stall_cycles)
  );

  fetch_unit_sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst_n (reset),
    .inc   (flush_inc),
    .count (flush_count)
  );

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming fetch, stall buffering, redirects,
// flush, async reset and counter saturation (narrow counters).
module tb_fetch_unit;
  import fetch_unit_pkg::*;

  localparam int CNT_W = 3;

  logic             clk;
  logic             rst_n;
  logic             pc_wr_en;
  logic             if_id_wr_en;
  logic             if_id_flush;
  logic             branch_taken;
  logic [31:0]      branch_target;
  logic             jump_en;
  logic [31:0]      jump_target;
  logic             imem_ack;
  logic [31:0]      imem_rdata;
  logic             imem_req;
  logic [31:0]      imem_addr;
  logic [31:0]      if_id_instr;
  logic [31:0]      if_id_pc4;
  logic             if_id_valid;
  logic [CNT_W-1:0] stall_cycles;
  logic [CNT_W-1:0] flush_count;
  logic [1:0]       dbg_state;

  int tests_run;
  int tests_failed;
  logic [31:0] exp_q[$];
  logic [31:0] exp_v;

  fetch_unit #(.RESET_PC(32'h0000_0000), .CNT_W(CNT_W)) dut (
    .clk               (clk),
    .reset             (rst_n),
    .PC_Wr_en          (pc_wr_en),
    .IF_ID_Wr_en       (if_id_wr_en),
    .IF_ID_flush       (if_id_flush),
    .Branch_taken      (branch_taken),
    .Branch_target     (branch_target),
    .Jump_en           (jump_en),
    .Jump_target       (jump_target),
    .imem_ack          (imem_ack),
    .imem_rdata        (imem_rdata),
    .imem_req          (imem_req),
    .imem_addr         (imem_addr),
    .IF_ID_Instruction (if_id_instr),
    .IF_ID_PC_plus4    (if_id_pc4),
    .IF_ID_valid       (if_id_valid),
    .stall_cycles      (stall_cycles),
    .flush_count       (flush_count),
    .dbg_state         (dbg_state)
  );

  // Clock / memory model: the instruction word encodes its own address.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  always_comb imem_rdata = 32'hC000_0000 | imem_addr;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic set_idle_inputs();
    pc_wr_en      = 1'b1;
    if_id_wr_en   = 1'b1;
    if_id_flush   = 1'b0;
    branch_taken  = 1'b0;
    branch_target = 32'h0;
    jump_en       = 1'b0;
    jump_target   = 32'h0;
    imem_ack      = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_req"},   {31'h0, imem_req}, 32'h0);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_instr"}, if_id_instr, 32'h0);
    check({tag, "_pc4"},   if_id_pc4, 32'h0);
    check({tag, "_valid"}, {31'h0, if_id_valid}, 32'h0);
    check({tag, "_stall"}, {29'h0, stall_cycles}, 32'h0);
    check({tag, "_flush"}, {29'h0, flush_count}, 32'h0);
    check({tag, "_state"}, {30'h0, dbg_state}, {30'h0, ST_IDLE});
  endtask

  initial begin
    tests_run    = 0;
    tests_failed = 0;
    set_idle_inputs();
    rst_n = 1'b1;
    #2 rst_n = 1'b0;

    // Reset values, then streaming fetch with ack tied high.
    tick();
    check_reset_outputs("rst");
    rst_n    = 1'b1;
    imem_ack = 1'b1;
    tick();
    check("t1_req", {31'h0, imem_req}, 32'h1);
    check("t1_addr0", imem_addr, 32'h0);
    check("t1_valid0", {31'h0, if_id_valid}, 32'h0);
    for (int i = 1; i <= 4; i++) exp_q.push_back(32'(4 * i));
    for (int i = 0; i < 4; i++) begin
      tick();
      exp_v = exp_q.pop_front();
      check("t1_pc4", if_id_pc4, exp_v);
      check("t1_instr", if_id_instr, 32'hC000_0000 | (exp_v - 32'd4));
      check("t1_valid", {31'h0, if_id_valid}, 32'h1);
      check("t1_addr", imem_addr, exp_v);
    end

    // Stall two cycles while ack is high: word parks in the buffer.
    pc_wr_en    = 1'b0;
    if_id_wr_en = 1'b0;
    tick();
    check("t2_state", {30'h0, dbg_state}, {30'h0, ST_FULL});
    check("t2_req", {31'h0, imem_req}, 32'h0);
    check("t2_hold_pc4", if_id_pc4, 32'h10);
    check("t2_stall1", {29'h0, stall_cycles}, 32'h1);
    tick();
    check("t2_stall2", {29'h0, stall_cycles}, 32'h2);
    check("t2_hold_instr", if_id_instr, 32'hC000_000C);
    pc_wr_en    = 1'b1;
    if_id_wr_en = 1'b1;
    imem_ack    = 1'b0;
    tick();
    check("t2_buf_instr", if_id_instr, 32'hC000_0010);
    check("t2_buf_pc4", if_id_pc4, 32'h14);
    check("t2_buf_valid", {31'h0, if_id_valid}, 32'h1);
    check("t2_next_addr", imem_addr, 32'h14);
    check("t2_stall_keep", {29'h0, stall_cycles}, 32'h2);

    // Branch while fetch is outstanding: drain old request, drop its word.
    branch_taken  = 1'b1;
    branch_target = 32'h100;
    tick();
    branch_taken = 1'b0;
    check("t3_state", {30'h0, dbg_state}, {30'h0, ST_DRAIN});
    check("t3_old_addr", imem_addr, 32'h14);
    check("t3_valid", {31'h0, if_id_valid}, 32'h0);
    tick();
    check("t3_still_drain", {30'h0, dbg_state}, {30'h0, ST_DRAIN});
    imem_ack = 1'b1;
    tick();
    check("t3_new_addr", imem_addr, 32'h100);
    check("t3_dropped", {31'h0, if_id_valid}, 32'h0);
    tick();
    check("t3_instr", if_id_instr, 32'hC000_0100);
    check("t3_pc4", if_id_pc4, 32'h104);

    // Branch and jump together, same cycle as an ack: branch wins.
    branch_taken  = 1'b1;
    branch_target = 32'h200;
    jump_en       = 1'b1;
    jump_target   = 32'h300;
    tick();
    branch_taken = 1'b0;
    jump_en      = 1'b0;
    check("t4_addr", imem_addr, 32'h200);
    check("t4_acked_dropped", {31'h0, if_id_valid}, 32'h0);
    tick();
    check("t4_pc4", if_id_pc4, 32'h204);

    // Flush during a stall: bubble, flush counted, stall not counted.
    if_id_flush = 1'b1;
    if_id_wr_en = 1'b0;
    pc_wr_en    = 1'b0;
    tick();
    check("t5_instr", if_id_instr, 32'h0);
    check("t5_valid", {31'h0, if_id_valid}, 32'h0);
    check("t5_flush", {29'h0, flush_count}, 32'h1);
    check("t5_stall", {29'h0, stall_cycles}, 32'h2);
    if_id_flush = 1'b0;
    if_id_wr_en = 1'b1;
    pc_wr_en    = 1'b1;
    imem_ack    = 1'b0;
    tick();
    check("t5_buf_instr", if_id_instr, 32'hC000_0204);
    check("t5_buf_pc4", if_id_pc4, 32'h208);

    // Async reset while draining; ack during IDLE is ignored.
    branch_taken  = 1'b1;
    branch_target = 32'h400;
    tick();
    branch_taken = 1'b0;
    check("t6_drain", {30'h0, dbg_state}, {30'h0, ST_DRAIN});
    #1 rst_n = 1'b0;
    #1;
    check_reset_outputs("t6_async");
    imem_ack = 1'b1;
    tick();
    rst_n = 1'b1;
    tick();
    check("t6_idle_ack_ignored", {31'h0, if_id_valid}, 32'h0);
    check("t6_restart_addr", imem_addr, 32'h0);
    tick();
    check("t6_first_pc4", if_id_pc4, 32'h4);
    check("t6_first_valid", {31'h0, if_id_valid}, 32'h1);

    // Counters saturate at all-ones.
    pc_wr_en    = 1'b0;
    if_id_wr_en = 1'b0;
    for (int i = 0; i < 9; i++) tick();
    check("sat_stall", {29'h0, stall_cycles}, 32'h7);
    if_id_flush = 1'b1;
    for (int i = 0; i < 9; i++) tick();
    check("sat_flush", {29'h0, flush_count}, 32'h7);
    check("sat_stall_keep", {29'h0, stall_cycles}, 32'h7);
    set_idle_inputs();
    tick();

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
